// File: rtl/reg_bank_pkg.sv
// ============================================================================
// Module  : reg_bank_pkg
// Brief   : Shared types and helpers for the reg_bank scratch register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_bank_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // A one-word bank still needs a 1-bit address port.
    function automatic int addr_width(input int depth);
        int aw;
        aw = $clog2(depth);
        return (aw < 1) ? 1 : aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_clr_seq.sv
// ============================================================================
// Module  : reg_bank_clr_seq
// Brief   : Bulk-clear sequencer: sweeps every word index once, asserting busy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clr seen mid-sweep is dropped; only IDLE can start a new sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module  : reg_bank
// Brief   : DEPTH x WIDTH register file, registered read, range check, bulk clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int WRITE_FIRST = 1,
    localparam int AW         = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             w,
    input  logic             r,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] DIn,
    input  logic             clr,
    output logic [WIDTH-1:0] DOut,
    output logic             rd_valid,
    output logic             busy,
    output logic             err
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;

    logic             seq_busy;
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             in_range;
    logic             access_ok;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    reg_bank_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (seq_busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign in_range  = ({1'b0, addr} < DEPTH_W);
    assign access_ok = cs & ~seq_busy & ~clr & in_range;
    assign wr_acc    = access_ok & w;
    assign rd_acc    = access_ok & r;

    // Same-address write and read: WRITE_FIRST forwards the incoming word.
    assign rd_data = (wr_acc && (WRITE_FIRST != 0)) ? DIn : mem_q[addr];

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end
        if (wr_acc) begin
            mem_d[addr] = DIn;
        end
        dout_d     = rd_acc ? rd_data : dout_q;
        rd_valid_d = rd_acc;
        err_d      = cs & (w | r) & (seq_busy | clr | ~in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign DOut     = dout_q;
    assign rd_valid = rd_valid_q;
    assign busy     = seq_busy;
    assign err      = err_q;

endmodule

`default_nettype wire
